lane_alu_pipe: RTL and testbench

//  Element-wise compute stage between the DRAM agent's read side and its write-back FIFO.
//  - Consumes operand beat pairs: read_data0 / read_data1 / read_data_ready.
//  - Splits each beat into LANES = DATA_WIDTH/LANE_WIDTH lanes and applies one latched op per lane.
//  - Returns the result as data_sum with a valid strobe that drives the agent's write-buffer enqueue.
//  - Counts results per job; raises done after mat_mem_len results.

---
 rtl/lane_alu_if.sv | 21 ++
 rtl/lane_alu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_lane_alu_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_alu_if.sv
// Operand/result bus between the DRAM agent's read side and the lane ALU.
// The master drives operand beats and receives results. The slave is the ALU stage.
interface lane_alu_if #(
    parameter int unsigned DATA_WIDTH = 512
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] data_sum;

    modport master (
        output in_valid, in_a, in_b,
        input  out_valid, data_sum
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output out_valid, data_sum
    );
endinterface

// File: rtl/lane_alu_pipe.sv
// Two-stage lane-wise ALU between the DRAM read side and the write-back FIFO, counting results per job.
// Define LANE_ALU_SATURATE_EN to build per-lane signed saturation and the sticky overflow flag.
module lane_alu_pipe #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [LEN_WIDTH-1:0] mat_mem_len,
    lane_alu_if.slave            bus,
    output logic [LEN_WIDTH-1:0] result_count,
    output logic                 done,
    output logic                 overflow
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e                state_q;
    state_e                state_d;
    op_e                   op_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  accepted_count;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [DATA_WIDTH-1:0] s2_result;
    logic                  accept_c;
    logic                  last_c;

`ifdef LANE_ALU_SATURATE_EN
    logic [LANES-1:0]      s2_sat;

    // Returns {saturated, lane result}; the sum keeps one guard bit and the product full width.
    function automatic logic [LANE_WIDTH:0] lane_calc(
        input op_e                   f_op,
        input logic [LANE_WIDTH-1:0] a,
        input logic [LANE_WIDTH-1:0] b
    );
        logic [LANE_WIDTH:0]     sum;
        logic [2*LANE_WIDTH-1:0] prod;
        logic [LANE_WIDTH-1:0]   max_v;
        logic [LANE_WIDTH-1:0]   min_v;
        logic [LANE_WIDTH:0]     res;
        max_v = {1'b0, {(LANE_WIDTH-1){1'b1}}};
        min_v = {1'b1, {(LANE_WIDTH-1){1'b0}}};
        sum   = '0;
        prod  = '0;
        res   = {1'b0, a};
        case (f_op)
            OP_ADD, OP_SUB: begin
                sum = (f_op == OP_ADD) ? ({a[LANE_WIDTH-1], a} + {b[LANE_WIDTH-1], b})
                                       : ({a[LANE_WIDTH-1], a} - {b[LANE_WIDTH-1], b});
                if (sum[LANE_WIDTH] != sum[LANE_WIDTH-1])
                    res = {1'b1, sum[LANE_WIDTH] ? min_v : max_v};
                else
                    res = {1'b0, sum[LANE_WIDTH-1:0]};
            end
            OP_MUL: begin
                prod = {{LANE_WIDTH{a[LANE_WIDTH-1]}}, a} * {{LANE_WIDTH{b[LANE_WIDTH-1]}}, b};
                if (prod[2*LANE_WIDTH-1:LANE_WIDTH-1] != {(LANE_WIDTH+1){prod[LANE_WIDTH-1]}})
                    res = {1'b1, prod[2*LANE_WIDTH-1] ? min_v : max_v};
                else
                    res = {1'b0, prod[LANE_WIDTH-1:0]};
            end
            default: res = {1'b0, a};
        endcase
        return res;
    endfunction
`else
    // Wrapping lane op; the low half of a product is the same for signed and unsigned operands.
    function automatic logic [LANE_WIDTH-1:0] lane_calc(
        input op_e                   f_op,
        input logic [LANE_WIDTH-1:0] a,
        input logic [LANE_WIDTH-1:0] b
    );
        logic [LANE_WIDTH-1:0] res;
        case (f_op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = a * b;
            default: res = a;
        endcase
        return res;
    endfunction
`endif

    assign accept_c = bus.in_valid && !start && (state_q == ST_RUN) && (accepted_count < len_q);
    assign last_c   = s1_valid && ((result_count + LEN_WIDTH'(1)) == len_q);

    // Job state: a zero-length job completes on the first cycle after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN:  if ((len_q == '0) || last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (start) state_d = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_ADD;
            len_q          <= '0;
            accepted_count <= '0;
            result_count   <= '0;
            s1_valid       <= 1'b0;
            bus.out_valid  <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == ST_DONE);
            if (start) begin
                op_q           <= op_e'(op);
                len_q          <= mat_mem_len;
                accepted_count <= '0;
                result_count   <= '0;
                s1_valid       <= 1'b0;
                bus.out_valid  <= 1'b0;
            end else begin
                s1_valid      <= accept_c;
                bus.out_valid <= s1_valid;
                if (accept_c) accepted_count <= accepted_count + LEN_WIDTH'(1);
                if (s1_valid) result_count <= result_count + LEN_WIDTH'(1);
            end
        end
    end

    // Lane-wise compute on the S1 operands.
    always_comb begin
        s2_result = '0;
`ifdef LANE_ALU_SATURATE_EN
        s2_sat = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
`ifdef LANE_ALU_SATURATE_EN
            {s2_sat[i], s2_result[i*LANE_WIDTH +: LANE_WIDTH]} =
                lane_calc(op_q, s1_a[i*LANE_WIDTH +: LANE_WIDTH], s1_b[i*LANE_WIDTH +: LANE_WIDTH]);
`else
            s2_result[i*LANE_WIDTH +: LANE_WIDTH] =
                lane_calc(op_q, s1_a[i*LANE_WIDTH +: LANE_WIDTH], s1_b[i*LANE_WIDTH +: LANE_WIDTH]);
`endif
        end
    end

    // Operand and result registers; data_sum holds between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_a         <= '0;
            s1_b         <= '0;
            bus.data_sum <= '0;
        end else begin
            if (accept_c) begin
                s1_a <= bus.in_a;
                s1_b <= bus.in_b;
            end
            if (s1_valid && !start) bus.data_sum <= s2_result;
        end
    end

`ifdef LANE_ALU_SATURATE_EN
    always_ff @(posedge clk) begin
        if (reset || start)
            overflow <= 1'b0;
        else if (s1_valid && (|s2_sat))
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_lane_alu_pipe.sv
// Directed bench for lane_alu_pipe: a scoreboard queue holds each accepted beat's due cycle and result.
// Honours LANE_ALU_SATURATE_EN in its reference model.
module tb_lane_alu_pipe;

    localparam int unsigned DW    = 512;
    localparam int unsigned LW    = 32;
    localparam int unsigned LENW  = 28;
    localparam int unsigned LANES = DW / LW;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      op;
    logic [LENW-1:0] mat_mem_len;
    logic [LENW-1:0] result_count;
    logic            done;
    logic            overflow;

    lane_alu_if #(.DATA_WIDTH(DW)) bus ();

    lane_alu_pipe #(
        .DATA_WIDTH (DW),
        .LANE_WIDTH (LW),
        .LEN_WIDTH  (LENW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .mat_mem_len  (mat_mem_len),
        .bus          (bus),
        .result_count (result_count),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            exp_rc = 0;
    logic [DW-1:0] last_data = '0;
    logic [1:0]    job_op = 2'b00;
    exp_t          sb[$];

    function automatic logic [LW-1:0] ref_lane(input logic [1:0] f_op, input logic [LW-1:0] a,
                                               input logic [LW-1:0] b);
        longint sa, sbv, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (f_op)
            2'b00:   r = sa + sbv;
            2'b01:   r = sa - sbv;
            2'b10:   r = sa * sbv;
            default: return a;
        endcase
`ifdef LANE_ALU_SATURATE_EN
        if (r > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (r < -64'sd2147483648) return 32'h8000_0000;
`endif
        return LW'(r);
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [1:0] f_op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LANES); i++)
            r[i*LW +: LW] = ref_lane(f_op, a[i*LW +: LW], b[i*LW +: LW]);
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [LW-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LANES); i++) r[i*LW +: LW] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; then compare the output bus against the scoreboard head.
    task automatic tick();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_v     = 1'b1;
            exp_d     = sb[0].data;
            last_data = exp_d;
            exp_rc++;
            void'(sb.pop_front());
        end else begin
            exp_v = 1'b0;
            exp_d = last_data;
        end
        chk("out_valid", DW'(bus.out_valid), DW'(exp_v));
        chk("data_sum", bus.data_sum, exp_d);
        chk("result_count", DW'(result_count), DW'(exp_rc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit acc);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        if (acc) sb.push_back('{cyc + 2, ref_beat(job_op, a, b)});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] o, input logic [LENW-1:0] len);
        start       = 1'b1;
        op          = o;
        mat_mem_len = len;
        job_op      = o;
        sb.delete();
        exp_rc = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        exp_rc    = 0;
        last_data = '0;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] va;
        logic [DW-1:0] vexp;
        logic [LW-1:0] lane0;

        reset        = 1'b0;
        start        = 1'b0;
        op           = 2'b00;
        mat_mem_len  = '0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;

        do_reset();
        chk("reset_done", DW'(done), '0);
        chk("reset_overflow", DW'(overflow), '0);
        idle(2);
        chk("idle_after_reset_done", DW'(done), '0);

        // add, len=1: result two cycles after the beat, done with the result
        do_start(2'b00, 28'd1);
        beat(fill(32'd1), fill(32'd2), 1'b1);
        chk("add_done_early", DW'(done), '0);
        tick();
        chk("add_valid_at_2", DW'(bus.out_valid), 1);
        chk("add_done", DW'(done), 1);
        chk("add_lanes", bus.data_sum, fill(32'd3));
        idle(2);
        chk("add_count", DW'(result_count), 1);

        // add at the positive limit of lane 0
        do_start(2'b00, 28'd1);
        chk("ovf_cleared", DW'(overflow), '0);
        va = fill(32'd1);
        va[LW-1:0] = 32'h7FFF_FFFF;
        beat(va, fill(32'd1), 1'b1);
        idle(3);
        vexp  = bus.data_sum;
        lane0 = vexp[LW-1:0];
`ifdef LANE_ALU_SATURATE_EN
        chk("wrap_lane0", DW'(lane0), DW'(32'h7FFF_FFFF));
        chk("wrap_overflow", DW'(overflow), 1);
`else
        chk("wrap_lane0", DW'(lane0), DW'(32'h8000_0000));
        chk("wrap_overflow", DW'(overflow), '0);
`endif

        // sub and mul
        do_start(2'b01, 28'd1);
        beat(fill(32'd5), fill(32'd7), 1'b1);
        idle(3);
        chk("sub_lanes", bus.data_sum, fill(32'hFFFF_FFFE));
        do_start(2'b10, 28'd1);
        beat(fill(32'h1_0000), fill(32'h1_0000), 1'b1);
        idle(3);
`ifdef LANE_ALU_SATURATE_EN
        chk("mul_lanes", bus.data_sum, fill(32'h7FFF_FFFF));
`else
        chk("mul_lanes", bus.data_sum, '0);
`endif

        // len=3 with five back-to-back beats; op input changes mid-job
        do_start(2'b00, 28'd3);
        op = 2'b10;
        beat(rand_beat(), rand_beat(), 1'b1);
        beat(rand_beat(), rand_beat(), 1'b1);
        beat(rand_beat(), rand_beat(), 1'b1);
        beat(rand_beat(), rand_beat(), 1'b0);
        beat(rand_beat(), rand_beat(), 1'b0);
        idle(3);
        chk("len3_count", DW'(result_count), 3);
        chk("len3_done", DW'(done), 1);
        beat(rand_beat(), rand_beat(), 1'b0);
        idle(3);
        chk("after_done_count", DW'(result_count), 3);

        // start while a beat sits in S1, then start with in_valid in the same cycle
        do_start(2'b00, 28'd2);
        beat(rand_beat(), rand_beat(), 1'b1);
        do_start(2'b01, 28'd2);
        idle(3);
        chk("flush_count", DW'(result_count), '0);
        chk("flush_done", DW'(done), '0);
        beat(fill(32'd10), fill(32'd3), 1'b1);
        idle(3);
        chk("new_op_sub", bus.data_sum, fill(32'd7));
        bus.in_valid = 1'b1;
        bus.in_a     = rand_beat();
        bus.in_b     = rand_beat();
        do_start(2'b11, 28'd2);
        bus.in_valid = 1'b0;
        beat(rand_beat(), rand_beat(), 1'b1);
        beat(rand_beat(), rand_beat(), 1'b1);
        idle(3);
        chk("same_cycle_count", DW'(result_count), 2);
        chk("same_cycle_done", DW'(done), 1);

        // every op on random data
        for (int k = 0; k < 4; k++) begin
            do_start(2'(k), 28'd4);
            for (int j = 0; j < 4; j++) beat(rand_beat(), rand_beat(), 1'b1);
            idle(3);
            chk("rand_done", DW'(done), 1);
        end

        // zero-length job, then reset
        do_start(2'b00, 28'd0);
        chk("len0_done_at_start", DW'(done), '0);
        tick();
        chk("len0_done", DW'(done), 1);
        beat(rand_beat(), rand_beat(), 1'b0);
        idle(3);
        do_reset();
        chk("final_reset_done", DW'(done), '0);
        chk("final_reset_overflow", DW'(overflow), '0);
        chk("final_reset_data", bus.data_sum, '0);
        chk("scoreboard_empty", DW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
